// File: rtl/comp_queue_nch.sv
// Multi-channel round-robin enqueue into a first-word-fall-through queue.
// Optional macro COMP_QUEUE_SRC_TAG_EN stores the granting channel ID with each entry.
module comp_queue_nch #(
  parameter int ADDRW  = 24,
  parameter int QDEPTH = 32,
  parameter int NCH    = 2,
  localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int CNTW  = $clog2(QDEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       valid_in,
  input  logic [NCH*ADDRW-1:0] dest_addr,
  output logic [NCH-1:0]       ready_out,
  input  logic                 flush,
  output logic [ADDRW-1:0]     data_out,
`ifdef COMP_QUEUE_SRC_TAG_EN
  output logic [CHW-1:0]       src_out,
`endif
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic [CNTW-1:0]      count
);

  localparam int PTRW = $clog2(QDEPTH);

  logic [PTRW-1:0]  head_q, head_d;
  logic [PTRW-1:0]  tail_q, tail_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic [CHW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ADDRW-1:0] mem_q [QDEPTH];
`ifdef COMP_QUEUE_SRC_TAG_EN
  logic [CHW-1:0]   tag_q [QDEPTH];
`endif

  logic             grant_vld;
  logic [CHW-1:0]   grant_idx;
  logic [CHW-1:0]   scan_idx;
  logic [ADDRW-1:0] grant_addr;
  logic             enq;
  logic             deq;

  // Cyclic search starting at rr_ptr; first requester found wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = 0; k < NCH; k++) begin
      scan_idx = CHW'((int'(rr_ptr_q) + k) % NCH);
      if (!grant_vld && valid_in[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  assign grant_addr = dest_addr[int'(grant_idx)*ADDRW +: ADDRW];

  // rst_n gating keeps ready_out low for the whole time reset is held.
  assign enq = rst_n && grant_vld && !flush && (count_q != CNTW'(QDEPTH));
  assign deq = rst_n && !flush && (count_q != '0) && ready_in;

  always_comb begin
    ready_out = '0;
    if (enq) ready_out[grant_idx] = 1'b1;
  end

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    rr_ptr_d = rr_ptr_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) begin
        tail_d   = tail_q + 1'b1;
        rr_ptr_d = CHW'((int'(grant_idx) + 1) % NCH);
      end
      if (deq) head_d = head_q + 1'b1;
      case ({enq, deq})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Storage is unreset; contents only matter while valid_out is high.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_q[tail_q] <= grant_addr;
`ifdef COMP_QUEUE_SRC_TAG_EN
      tag_q[tail_q] <= grant_idx;
`endif
    end
  end

  assign data_out  = mem_q[head_q];
`ifdef COMP_QUEUE_SRC_TAG_EN
  assign src_out   = tag_q[head_q];
`endif
  assign valid_out = (count_q != '0);
  assign count     = count_q;

endmodule

// File: tb/tb_comp_queue_nch.sv
// Scoreboard bench for comp_queue_nch (NCH=4, QDEPTH=8): directed stimulus pushes
// expected entries, a negedge monitor pops them on every output transfer.
module tb_comp_queue_nch;

  localparam int ADDRW  = 24;
  localparam int QDEPTH = 8;
  localparam int NCH    = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NCH-1:0]   valid_in;
  logic [NCH*ADDRW-1:0] dest_addr;
  logic [NCH-1:0]   ready_out;
  logic             flush;
  logic [ADDRW-1:0] data_out;
`ifdef COMP_QUEUE_SRC_TAG_EN
  logic [1:0]       src_out;
`endif
  logic             valid_out;
  logic             ready_in;
  logic [3:0]       count;

  comp_queue_nch #(.ADDRW(ADDRW), .QDEPTH(QDEPTH), .NCH(NCH)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .dest_addr(dest_addr),
    .ready_out(ready_out), .flush(flush), .data_out(data_out),
`ifdef COMP_QUEUE_SRC_TAG_EN
    .src_out(src_out),
`endif
    .valid_out(valid_out), .ready_in(ready_in), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDRW-1:0] addr;
    logic [1:0]       ch;
  } ent_t;

  ent_t exp_q[$];
  ent_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   pops     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: a transfer happens at the next edge whenever valid_out && ready_in.
  always @(negedge clk) begin
    if (rst_n && valid_out && ready_in && !flush) begin
      pops++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=0x%0h required=no_entry", data_out);
      end else begin
        mon_e = exp_q.pop_front();
        chk("data_out", 32'(data_out), 32'(mon_e.addr));
`ifdef COMP_QUEUE_SRC_TAG_EN
        chk("src_out", 32'(src_out), 32'(mon_e.ch));
`endif
        $display("deq data=0x%06h ch=%0d", mon_e.addr, mon_e.ch);
      end
    end
  end

  // One clock of stimulus; exp_cnt < 0 skips the occupancy check.
  task automatic step(input logic [3:0] vin, input logic [23:0] base, input logic rin,
                      input logic fl, input logic [3:0] exp_rdy, input int exp_cnt,
                      input string name);
    ent_t e;
    valid_in = vin;
    ready_in = rin;
    flush    = fl;
    for (int i = 0; i < NCH; i++) dest_addr[i*ADDRW +: ADDRW] = base + 24'(i);
    @(negedge clk);
    chk({name, "_ready_out"}, 32'(ready_out), 32'(exp_rdy));
    if (exp_cnt >= 0) begin
      chk({name, "_count"}, 32'(count), 32'(exp_cnt));
      chk({name, "_valid_out"}, 32'(valid_out), 32'(exp_cnt != 0));
    end
    for (int i = 0; i < NCH; i++) begin
      if (exp_rdy[i]) begin
        e.addr = base + 24'(i);
        e.ch   = 2'(i);
        exp_q.push_back(e);
        $display("enq ch=%0d data=0x%06h", i, e.addr);
      end
    end
    if (fl) exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; valid_in = 4'hF; ready_in = 1'b0; flush = 1'b0; dest_addr = '0;
    @(negedge clk);
    chk("reset_ready_out", 32'(ready_out), 32'h0);
    chk("reset_valid_out", 32'(valid_out), 32'h0);
    chk("reset_count", 32'(count), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fill with all channels requesting: strict rotation 0,1,2,3,...
    for (int c = 0; c < 8; c++)
      step(4'hF, 24'(c << 8), 1'b0, 1'b0, 4'(1 << (c % 4)), c, "fill_rr");
    step(4'hF, 24'h000800, 1'b0, 1'b0, 4'b0000, 8, "full_hold");

    // Full with simultaneous dequeue: enqueue still refused, then accepted.
    step(4'b0001, 24'h000900, 1'b1, 1'b0, 4'b0000, 8, "full_deq");
    step(4'b0001, 24'h000A00, 1'b0, 1'b0, 4'b0001, 7, "refill");
    for (int c = 0; c < 8; c++)
      step(4'b0000, 24'h0, 1'b1, 1'b0, 4'b0000, 8 - c, "drain");
    step(4'b0000, 24'h0, 1'b1, 1'b0, 4'b0000, 0, "empty_deq");

    // Single channel 2, address 0x000ABC; rr_ptr is 1 here.
    step(4'b0100, 24'h000ABA, 1'b0, 1'b0, 4'b0100, 0, "ch2_enq");
    step(4'b0000, 24'h0, 1'b1, 1'b0, 4'b0000, 1, "ch2_deq");
    step(4'b0000, 24'h0, 1'b0, 1'b0, 4'b0000, 0, "ch2_after");

    // Streaming on channel 1 for 40 cycles; occupancy stays at 1.
    for (int c = 0; c < 40; c++)
      step(4'b0010, 24'(24'h005000 + c * 16), 1'b1, 1'b0, 4'b0010, (c == 0) ? 0 : 1, "stream");
    step(4'b0000, 24'h0, 1'b1, 1'b0, 4'b0000, 1, "stream_tail");
    step(4'b0000, 24'h0, 1'b0, 1'b0, 4'b0000, 0, "stream_done");

    // Fill to 5, then flush with a request pending; rr_ptr (2) survives.
    for (int c = 0; c < 5; c++)
      step(4'b0010, 24'(24'h006000 + c * 16), 1'b0, 1'b0, 4'b0010, c, "pre_flush");
    step(4'b0010, 24'h007000, 1'b0, 1'b1, 4'b0000, 5, "flush");
    step(4'b0000, 24'h0, 1'b0, 1'b0, 4'b0000, 0, "post_flush");
    step(4'hF, 24'h008000, 1'b0, 1'b0, 4'b0100, 0, "rr_kept");
    step(4'hF, 24'h008100, 1'b0, 1'b0, 4'b1000, 1, "rr_next3");
    step(4'hF, 24'h008200, 1'b0, 1'b0, 4'b0001, 2, "rr_next0");

    // Asynchronous reset between edges at count=3.
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid_out", 32'(valid_out), 32'h0);
    chk("async_rst_count", 32'(count), 32'h0);
    chk("async_rst_ready_out", 32'(ready_out), 32'h0);
    exp_q.delete();
    #1;
    rst_n = 1'b1;
    step(4'b1010, 24'h009000, 1'b0, 1'b0, 4'b0010, 0, "post_rst_grant");
    step(4'b0000, 24'h0, 1'b1, 1'b0, 4'b0000, 1, "post_rst_deq");
    step(4'b0000, 24'h0, 1'b0, 1'b0, 4'b0000, 0, "post_rst_empty");

    chk("scoreboard_left", 32'(exp_q.size()), 32'h0);
    chk("total_outputs", 32'(pops), 32'd51);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/comp_queue_nch.md
COMP_QUEUE_NCH -- requirements
Module: comp_queue_nch

Interface
REQ-001 SHALL provide parameter ADDRW, default 24, width of one destination-address entry.
REQ-002 SHALL provide parameter QDEPTH, default 32, entry count; power of two, at least 2.
REQ-003 SHALL provide parameter NCH, default 2, number of producer channels, at least 2; CHW = max(1, $clog2(NCH)).
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 valid_in  input  NCH  per-channel request; bit i = channel i.
REQ-007 dest_addr  input  NCH*ADDRW  packed addresses; channel i at bits [i*ADDRW +: ADDRW].
REQ-008 ready_out  output  NCH  per-channel accept; transfer on channel i when valid_in[i] and ready_out[i] are both high.
REQ-009 flush  input  1  synchronous queue clear.
REQ-010 data_out  output  ADDRW  head entry.
REQ-011 src_out  output  CHW  channel ID of head entry; present only with COMP_QUEUE_SRC_TAG_EN.
REQ-012 valid_out  output  1  head entry valid.
REQ-013 ready_in  input  1  consumer accept; dequeue when valid_out and ready_in are both high.
REQ-014 count  output  $clog2(QDEPTH+1)  current occupancy, registered.

Function
REQ-015 Arbiter SHALL be round-robin: grant = first channel with valid_in high, searching cyclically from rr_ptr (CHW bits).
REQ-016 ready_out[i] SHALL be high only when i is the grant, count < QDEPTH and flush is low; at most one bit high per cycle; combinational.
REQ-017 rr_ptr SHALL load (grant+1) mod NCH only on an accepted enqueue; otherwise it SHALL hold, so a stalled requester is never skipped.
REQ-018 Enqueue SHALL write the granted address at tail; tail increments modulo QDEPTH.
REQ-019 Output SHALL be first-word-fall-through: valid_out = (count != 0); data_out = mem[head], from registered state only, no combinational path from ready_in.
REQ-020 Dequeue SHALL advance head modulo QDEPTH; a data word SHALL appear on data_out exactly once, in enqueue order.
REQ-021 Same-cycle enqueue and dequeue SHALL leave count unchanged, with both pointers advancing.
REQ-022 When full (count == QDEPTH), enqueue SHALL be refused even if a dequeue occurs that cycle.
REQ-023 When empty, ready_in SHALL have no effect and count SHALL never underflow.
REQ-024 Write-through latency SHALL be one cycle: an entry accepted at edge N into an empty queue is visible with valid_out high after edge N.
REQ-025 flush SHALL clear head, tail and count at the next edge, with no enqueue or dequeue taking effect that cycle; rr_ptr SHALL be retained.
REQ-026 Entry storage SHALL need no reset; outputs SHALL be qualified by valid_out.

Reset
REQ-027 rst_n low SHALL asynchronously clear head, tail, count and rr_ptr to 0, so that valid_out = 0 and ready_out = 0 while reset is asserted.
REQ-028 After rst_n rises, the first enqueue SHALL be possible at the first rising edge, with channel 0 highest priority.
REQ-029 Reset asserted mid-operation SHALL discard all entries, with no output transfer reported after assertion.

Configuration
REQ-030 With COMP_QUEUE_SRC_TAG_EN defined, each entry SHALL store the grant index with the address, and src_out SHALL present the head entry's ID alongside data_out.
REQ-031 Without COMP_QUEUE_SRC_TAG_EN, the src_out port and tag storage SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 NCH=4, QDEPTH=8, all valid_in=4'b1111 held, ready_in=0 -> grants 0,1,2,3,0,1,2,3; count reaches 8; ready_out=0 thereafter.
REQ-033 Only ch2 valid with addr 0x000ABC, then ready_in=1 -> valid_out high one cycle later with data_out=0x000ABC (src_out=2 when tagged); count returns to 0.
REQ-034 Queue full (8), ready_in=1 and valid_in[0]=1 in the same cycle -> one dequeue, no enqueue, count=7; enqueue accepted next cycle, count=8.
REQ-035 Steady streaming with ready_in=1 and one channel valid every cycle for 40 cycles -> count stays 1, pointers wrap past 7 with no loss, order preserved.
REQ-036 count=5, flush=1 with valid_in[1]=1 -> ready_out=0 that cycle; next cycle count=0 and valid_out=0; rr_ptr unchanged.
REQ-037 rst_n pulsed low asynchronously at count=3 between edges -> valid_out and count drop immediately; after release, the first grant goes to the lowest valid channel.
